fcmp_pipe: RTL and testbench

//  Parametrised, pipelined IEEE-754 binary compare/min/max unit for the FPU.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fcmp_pipe_if.sv | 44 ++++
 rtl/fcmp_core.sv | 113 +++++++++++
 rtl/fcmp_pipe.sv | 95 +++++++++
 tb/tb_fcmp_pipe.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU compare definitions: operation encoding, operand class record
// and the canonical quiet-NaN helper.
package fpu_pkg;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_e;

  typedef struct packed {
    logic is_zero;
    logic is_sub;
    logic is_inf;
    logic is_qnan;
    logic is_snan;
    logic sign;
  } fp_class_t;

  // Canonical quiet NaN: sign 0, exponent all ones, mantissa MSB set, rest 0.
  // Returned right-aligned in 64 bits; callers keep the low 1+exp_w+man_w bits.
  function automatic logic [63:0] FCMP_CANON_NAN(input int unsigned exp_w,
                                                 input int unsigned man_w);
    logic [63:0] exp_ones;
    exp_ones = (64'd1 << exp_w) - 64'd1;
    return (exp_ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fcmp_pipe_if.sv
// Handshake/data bundle of the compare unit.
//  in_valid/in_ready/in_op/in_x1/in_x2/in_tag : issue side
//  out_valid/out_ready/out_y/out_tag          : writeback side
//  out_nv : invalid-operation flag, present only with FCMP_NV_FLAG_EN
// modport slave = the compare unit, modport master = issue/writeback logic.
interface fcmp_pipe_if
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 5
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [W-1:0]     in_x1;
  logic [W-1:0]     in_x2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;
`ifdef FCMP_NV_FLAG_EN
  logic             out_nv;
`endif

  modport slave (
    input  in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag
`ifdef FCMP_NV_FLAG_EN
    , out_nv
`endif
  );

  modport master (
    output in_valid, in_op, in_x1, in_x2, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag
`ifdef FCMP_NV_FLAG_EN
    , out_nv
`endif
  );
endinterface

// File: rtl/fcmp_core.sv
// Combinational classify / compare / select core of the compare unit.
//  op_i      : operation (fcmp_op_e, other codes reserved -> result 0)
//  x1_i/x2_i : operands
//  y_o       : compare result {W-1 zeros, bit} or selected min/max operand
//  nv_o      : IEEE invalid flag (only with FCMP_NV_FLAG_EN)
module fcmp_core
  import fpu_pkg::*;
#(
  parameter  int unsigned EXP_W = 8,
  parameter  int unsigned MAN_W = 23,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic [2:0]   op_i,
  input  logic [W-1:0] x1_i,
  input  logic [W-1:0] x2_i,
`ifdef FCMP_NV_FLAG_EN
  output logic         nv_o,
`endif
  output logic [W-1:0] y_o
);

  localparam logic [63:0] CANON64 = FCMP_CANON_NAN(EXP_W, MAN_W);

  function automatic fp_class_t classify(input logic [W-1:0] x);
    fp_class_t        c;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    e         = x[W-2 -: EXP_W];
    m         = x[MAN_W-1:0];
    c.sign    = x[W-1];
    c.is_zero = (e == '0) && (m == '0);
    c.is_sub  = (e == '0) && (m != '0);
    c.is_inf  = (&e) && (m == '0);
    c.is_qnan = (&e) && m[MAN_W-1];
    c.is_snan = (&e) && !m[MAN_W-1] && (m != '0);
    return c;
  endfunction

  function automatic logic is_nan(input logic [W-1:0] x);
    fp_class_t c;
    c = classify(x);
    return c.is_qnan | c.is_snan;
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    fp_class_t c;
    c = classify(x);
    return c.is_zero;
  endfunction

`ifdef FCMP_NV_FLAG_EN
  function automatic logic is_snan(input logic [W-1:0] x);
    fp_class_t c;
    c = classify(x);
    return c.is_snan;
  endfunction
`endif

  // Sign-magnitude to a key whose unsigned order is the numeric order
  // (with -0 just below +0, which is what FMIN/FMAX want).
  function automatic logic [W-1:0] order_key(input logic [W-1:0] x);
    return x[W-1] ? ~x : {1'b1, x[W-2:0]};
  endfunction

  logic         nan1, nan2, any_nan, both_zero;
  logic [W-1:0] k1, k2;
  logic         k_lt, k_gt, eq, lt;

  always_comb begin
    nan1      = is_nan(x1_i);
    nan2      = is_nan(x2_i);
    any_nan   = nan1 | nan2;
    both_zero = is_zero(x1_i) & is_zero(x2_i);
    k1        = order_key(x1_i);
    k2        = order_key(x2_i);
    k_lt      = k1 < k2;
    k_gt      = k2 < k1;
    // Relational results treat the two zeros as equal, unlike the keys.
    eq        = !any_nan && ((x1_i == x2_i) || both_zero);
    lt        = !any_nan && !both_zero && k_lt;

    y_o = '0;
    case (fcmp_op_e'(op_i))
      FEQ:  y_o = {{(W-1){1'b0}}, eq};
      FLT:  y_o = {{(W-1){1'b0}}, lt};
      FLE:  y_o = {{(W-1){1'b0}}, lt | eq};
      FMIN: begin
        if (nan1 && nan2) y_o = CANON64[W-1:0];
        else if (nan1)    y_o = x2_i;
        else if (nan2)    y_o = x1_i;
        else              y_o = k_gt ? x2_i : x1_i;
      end
      FMAX: begin
        if (nan1 && nan2) y_o = CANON64[W-1:0];
        else if (nan1)    y_o = x2_i;
        else if (nan2)    y_o = x1_i;
        else              y_o = k_lt ? x2_i : x1_i;
      end
      default: y_o = '0;
    endcase
  end

`ifdef FCMP_NV_FLAG_EN
  always_comb begin
    nv_o = 1'b0;
    if (op_i <= 3'd4) begin
      nv_o = is_snan(x1_i) | is_snan(x2_i) |
             ((op_i == 3'd1 || op_i == 3'd2) && any_nan);
    end
  end
`endif

endmodule

// File: rtl/fcmp_pipe.sv
// Pipelined IEEE-754 compare/min/max unit (FEQ/FLT/FLE/FMIN/FMAX).
//  clk   : clock, rising edge
//  rstn  : asynchronous active-low reset
//  flush : synchronous kill of every in-flight op (and of a same-cycle accept)
//  bus   : fcmp_pipe_if.slave handshake/data bundle
// Latency STAGES (1..3) advancing cycles, throughput 1/cycle.
// Optional macro FCMP_NV_FLAG_EN adds the out_nv invalid flag.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  fcmp_pipe_if.slave  bus
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  typedef struct packed {
    logic [W-1:0]     y;
    logic [TAG_W-1:0] tag;
`ifdef FCMP_NV_FLAG_EN
    logic             nv;
`endif
  } data_t;

  typedef data_t [STAGES-1:0] data_vec_t;

  logic [STAGES-1:0] vld_q, vld_d;
  data_vec_t         data_q, data_d;
  data_t             head;
  logic              advance;
  logic [W-1:0]      core_y;
`ifdef FCMP_NV_FLAG_EN
  logic              core_nv;
`endif

  // The whole classify/compare/select core sits ahead of the first register;
  // extra stages only delay the result, so every depth behaves identically.
  fcmp_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_core (
    .op_i (bus.in_op),
    .x1_i (bus.in_x1),
    .x2_i (bus.in_x2),
`ifdef FCMP_NV_FLAG_EN
    .nv_o (core_nv),
`endif
    .y_o  (core_y)
  );

  always_comb begin
    advance  = !vld_q[STAGES-1] || bus.out_ready;
    head     = '0;
    head.y   = core_y;
    head.tag = bus.in_tag;
`ifdef FCMP_NV_FLAG_EN
    head.nv  = core_nv;
`endif
    vld_d  = vld_q;
    data_d = data_q;
    // Shift by concatenating the new head below and truncating the oldest
    // entry off the top; this also covers STAGES=1 without a slice.
    if (advance) begin
      vld_d  = STAGES'({vld_q, bus.in_valid});
      data_d = data_vec_t'({data_q, head});
    end
    if (flush) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.out_y     = data_q[STAGES-1].y;
  assign bus.out_tag   = data_q[STAGES-1].tag;
`ifdef FCMP_NV_FLAG_EN
  assign bus.out_nv    = data_q[STAGES-1].nv;
`endif

endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe (binary32, STAGES=2): directed corner
// cases, stall/flush/latency sequences, then randomized traffic against a
// real-number reference model, with an asynchronous reset mid-stream.
module tb_fcmp_pipe;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAG_W  = 5;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
    logic        nv;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic flush;

  fcmp_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) bus ();

  fcmp_pipe #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .STAGES(STAGES),
    .TAG_W (TAG_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .flush(flush),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_deliv  = 0;
  exp_t        expq[$];
  logic        last_out_valid, last_acc;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_y;
  logic [4:0]  prev_tag;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (numeric values, not bit tricks) -------
  function automatic logic is_nan32(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
  endfunction

  function automatic real fp_val(input logic [31:0] x);
    int  e;
    real m, v;
    e = int'(x[30:23]);
    if (e == 255) v = 1.0e300;
    else begin
      m = real'(x[22:0]);
      if (e == 0) e = 1;
      else m = m + 8388608.0;
      v = m * (2.0 ** (e - 150));
    end
    return x[31] ? -v : v;
  endfunction

  function automatic logic [31:0] ref_y(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic na, nb;
    real  va, vb;
    na = is_nan32(a);
    nb = is_nan32(b);
    va = fp_val(a);
    vb = fp_val(b);
    case (op)
      3'd0: return {31'd0, !(na || nb) && (va == vb)};
      3'd1: return {31'd0, !(na || nb) && (va < vb)};
      3'd2: return {31'd0, !(na || nb) && (va <= vb)};
      3'd3, 3'd4: begin
        if (na && nb) return 32'h7fc00000;
        if (na) return b;
        if (nb) return a;
        if (va < vb) return (op == 3'd3) ? a : b;
        if (vb < va) return (op == 3'd3) ? b : a;
        // equal values: only distinct encodings are the two zeros
        if (op == 3'd3) return a[31] ? a : b;
        return a[31] ? b : a;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_nv(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
    logic sa, sb;
    sa = is_nan32(a) && !a[22];
    sb = is_nan32(b) && !b[22];
    if (op > 3'd4) return 1'b0;
    return sa || sb || ((op == 3'd1 || op == 3'd2) && (is_nan32(a) || is_nan32(b)));
  endfunction

  function automatic logic [31:0] rand_fp();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0: return {s, 31'd0};
      1: return {s, 8'h00, 23'($urandom_range(1, 8388607))};
      2: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
      3: return {s, 8'hff, 23'd0};
      4: return {s, 8'hff, 1'b1, 22'($urandom)};
      5: return {s, 8'hff, 1'b0, 22'($urandom_range(1, 4194303))};
      6: return {s, 8'($urandom_range(125, 128)), 23'($urandom_range(0, 3))};
      default: return 32'($urandom);
    endcase
  endfunction

  // ---------------- one clock cycle of drive + sample ----------------------
  task automatic cycle(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg, input logic rdy,
                       input logic fl, input logic [31:0] ey);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_x1     = a;
    bus.in_x2     = b;
    bus.in_tag    = tg;
    bus.out_ready = rdy;
    flush         = fl;
    #1;
    last_out_valid = bus.out_valid;
    check("in_ready", 64'(bus.in_ready), 64'(!bus.out_valid || rdy));
    if (prev_stall) begin
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_y", 64'(bus.out_y), 64'(prev_y));
      check("stall_tag", 64'(bus.out_tag), 64'(prev_tag));
    end
    prev_stall = bus.out_valid && !rdy && !fl;
    prev_y     = bus.out_y;
    prev_tag   = bus.out_tag;
    if (bus.out_valid && rdy) begin
      n_deliv++;
      if (expq.size() == 0) check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
      else begin
        e = expq.pop_front();
        check("out_y", 64'(bus.out_y), 64'(e.y));
        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
`ifdef FCMP_NV_FLAG_EN
        check("out_nv", 64'(bus.out_nv), 64'(e.nv));
`endif
      end
    end
    last_acc = v && bus.in_ready;
    if (fl) expq.delete();
    else if (last_acc) begin
      e.y   = ey;
      e.tag = tg;
      e.nv  = ref_nv(op, a, b);
      expq.push_back(e);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tg, input logic [31:0] ey);
    cycle(1'b1, op, a, b, tg, 1'b1, 1'b0, ey);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, rdy, 1'b0, 32'd0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (expq.size() != 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    check(tag, 64'(expq.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int          n, acc, c;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [4:0]  tg;

    rstn = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 3'd0;
    bus.in_x1 = '0;
    bus.in_x2 = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_y", 64'(bus.out_y), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    rstn = 1'b1;

    // zeros and ordering corners
    send(3'd2, 32'h80000000, 32'h00000000, 5'd1, 32'd1);
    send(3'd2, 32'h00000000, 32'h80000000, 5'd2, 32'd1);
    send(3'd0, 32'h80000000, 32'h00000000, 5'd3, 32'd1);
    send(3'd1, 32'h80000000, 32'h00000000, 5'd4, 32'd0);
    send(3'd1, 32'h00000000, 32'h80000000, 5'd5, 32'd0);
    send(3'd3, 32'h7fc00000, 32'h3f800000, 5'd6, 32'h3f800000);
    send(3'd3, 32'h7fc00000, 32'h7fc00000, 5'd7, 32'h7fc00000);
    send(3'd4, 32'h7fa00000, 32'hffc00001, 5'd8, 32'h7fc00000);
    send(3'd3, 32'h00000000, 32'h80000000, 5'd9, 32'h80000000);
    send(3'd4, 32'h00000000, 32'h80000000, 5'd10, 32'h00000000);
    send(3'd1, 32'hbf800000, 32'h00000001, 5'd11, 32'd1);
    send(3'd2, 32'h7f7fffff, 32'h7f7fffff, 5'd12, 32'd1);
    send(3'd0, 32'h7fc00000, 32'h7fc00000, 5'd13, 32'd0);
    send(3'd2, 32'hff800001, 32'hff800001, 5'd14, 32'd0);
    send(3'd1, 32'h00000001, 32'h00000002, 5'd15, 32'd1);
    send(3'd7, 32'h3f800000, 32'h3f800000, 5'd16, 32'd0);
    drain("drain_directed");

    // 8 back-to-back ops, consumer stalls in cycles 3..5
    n_deliv = 0;
    acc = 0;
    c = 0;
    while (acc < 8 && c < 40) begin
      a = rand_fp();
      b = rand_fp();
      op = 3'($urandom_range(0, 4));
      cycle(1'b1, op, a, b, 5'(acc), !(c >= 3 && c <= 5), 1'b0, ref_y(op, a, b));
      if (last_acc) acc++;
      c++;
    end
    check("b2b_accepted", 64'(acc), 64'd8);
    drain("drain_b2b");
    check("b2b_delivered", 64'(n_deliv), 64'd8);

    // flush with two ops in flight plus a same-cycle accept
    send(3'd0, 32'h3f800000, 32'h3f800000, 5'd20, 32'd1);
    send(3'd0, 32'h3f800000, 32'h3f800000, 5'd21, 32'd1);
    cycle(1'b1, 3'd0, 32'h3f800000, 32'h3f800000, 5'd22, 1'b1, 1'b1, 32'd1);
    repeat (STAGES + 2) begin
      idle(1'b1);
      check("flush_out_valid", 64'(last_out_valid), 64'd0);
    end
    send(3'd1, 32'h3f800000, 32'h40000000, 5'd23, 32'd1);
    n = 0;
    do begin
      idle(1'b1);
      n++;
    end while (!last_out_valid && n < 10);
    check("latency_after_flush", 64'(n), 64'(STAGES));
    drain("drain_flush");

    // randomized traffic with occasional flush and one async reset
    tg = 5'd0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        repeat (4) begin
          a = rand_fp();
          b = rand_fp();
          op = 3'($urandom_range(0, 4));
          cycle(1'b1, op, a, b, tg, 1'b0, 1'b0, ref_y(op, a, b));
          tg++;
        end
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_out_y", 64'(bus.out_y), 64'd0);
        expq.delete();
        prev_stall = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
      a = rand_fp();
      case ($urandom_range(0, 5))
        0: b = a;
        1: b = a ^ 32'h80000000;
        default: b = rand_fp();
      endcase
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cycle(1'($urandom_range(0, 3) != 0), op, a, b, tg, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 99) == 0), ref_y(op, a, b));
      if (last_acc) tg++;
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
